// File: rtl/frog_bus_mem.sv
// Program/data nibble memory on the frog CPU bus, with a handshaked loader that holds the CPU in reset.
// Optional CPU write protection of addresses 0..PROT_TOP is enabled by defining FROG_MEM_WP_EN.
module frog_bus_mem #(
    parameter int unsigned       ADDR_W   = 7,
    parameter int unsigned       DATA_W   = 4,
    parameter logic [ADDR_W-1:0] PROT_TOP = 7'h3F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_daout,
    input  logic              cpu_wcyc,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              wp_hit
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] NOP      = DATA_W'(4'h8);
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

`ifdef FROG_MEM_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    typedef enum logic {
        RUN,
        LOAD
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] last_addr, last_addr_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [DATA_W-1:0] cpu_data_nx;
    logic              cpu_rst_n_nx;
    logic              ld_ready_nx;
    logic              ld_done_nx;
    logic              wp_drop;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // CPU writes (RUN) and loader writes (LOAD) never coincide, so one write port serves both.
    always_comb begin
        state_nx     = state;
        last_addr_nx = last_addr;
        ptr_nx       = ptr;
        cpu_data_nx  = cpu_data;
        cpu_rst_n_nx = 1'b0;
        ld_ready_nx  = 1'b0;
        ld_done_nx   = 1'b0;
        wp_drop      = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = ptr;
        mem_wdata    = ld_data;

        case (state)
            RUN: begin
                cpu_rst_n_nx = 1'b1;
                if (cpu_wcyc) begin
                    wp_drop   = WP_EN && (last_addr <= PROT_TOP);
                    mem_we    = !wp_drop;
                    mem_waddr = last_addr;
                    mem_wdata = cpu_daout[DATA_W-1:0];
                end else begin
                    last_addr_nx = cpu_daout;
                    cpu_data_nx  = mem[cpu_daout];
                end
                if (ld_start) begin
                    state_nx     = LOAD;
                    ptr_nx       = '0;
                    cpu_rst_n_nx = 1'b0;
                    ld_ready_nx  = 1'b1;
                end
            end
            LOAD: begin
                cpu_data_nx = NOP;
                ld_ready_nx = 1'b1;
                if (ld_start) begin
                    ptr_nx = '0;
                    if (ld_valid && ld_ready) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        ptr_nx    = ADDR_W'(1);
                    end
                end else if (ld_valid && ld_ready) begin
                    mem_we = 1'b1;
                    ptr_nx = ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        state_nx    = RUN;
                        ld_ready_nx = 1'b0;
                        ld_done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            last_addr <= '0;
            ptr       <= '0;
            cpu_data  <= NOP;
            cpu_rst_n <= 1'b0;
            ld_ready  <= 1'b0;
            ld_done   <= 1'b0;
        end else begin
            state     <= state_nx;
            last_addr <= last_addr_nx;
            ptr       <= ptr_nx;
            cpu_data  <= cpu_data_nx;
            cpu_rst_n <= cpu_rst_n_nx;
            ld_ready  <= ld_ready_nx;
            ld_done   <= ld_done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP;
            end
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef FROG_MEM_WP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_hit <= 1'b0;
        end else begin
            wp_hit <= wp_drop;
        end
    end
`else
    assign wp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_frog_bus_mem.sv
// Self-checking bench for frog_bus_mem: vector table, directed load/restart/reset sequences,
// and randomized traffic compared against a transaction-level memory model.
module tb_frog_bus_mem;

`ifdef FROG_MEM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] cpu_daout;
    logic       cpu_wcyc;
    logic [3:0] cpu_data;
    logic       cpu_rst_n;
    logic       ld_start;
    logic       ld_valid;
    logic [3:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic       wp_hit;

    frog_bus_mem #(
        .ADDR_W  (7),
        .DATA_W  (4),
        .PROT_TOP(7'h3F)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_daout(cpu_daout),
        .cpu_wcyc (cpu_wcyc),
        .cpu_data (cpu_data),
        .cpu_rst_n(cpu_rst_n),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .wp_hit   (wp_hit)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model: memory image plus the visible output values.
    logic [3:0]  m_mem [128];
    bit          m_load;
    int unsigned m_ptr;
    logic [6:0]  m_last;
    logic [3:0]  m_data;
    logic        m_rst_n, m_ready, m_done, m_wp;

    typedef struct {
        logic [6:0] a;
        logic       w;
        logic [3:0] exp_data;
        logic       exp_rst_n;
        logic       exp_wp;
        string      name;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 4'h8;
        m_load  = 0;
        m_ptr   = 0;
        m_last  = '0;
        m_data  = 4'h8;
        m_rst_n = 0;
        m_ready = 0;
        m_done  = 0;
        m_wp    = 0;
    endtask

    task automatic model_step(input logic [6:0] a, input logic w, input logic s,
                              input logic v, input logic [3:0] d);
        m_done = 0;
        m_wp   = 0;
        if (!m_load) begin
            if (!w) begin
                m_last = a;
                m_data = m_mem[a];
            end else if (WP && m_last <= 7'h3F) begin
                m_wp = 1;
            end else begin
                m_mem[m_last] = a[3:0];
            end
            if (s) begin
                m_load  = 1;
                m_ptr   = 0;
                m_rst_n = 0;
                m_ready = 1;
            end else begin
                m_rst_n = 1;
                m_ready = 0;
            end
        end else begin
            m_data  = 4'h8;
            m_rst_n = 0;
            m_ready = 1;
            if (s) begin
                m_ptr = 0;
                if (v) begin
                    m_mem[0] = d;
                    m_ptr    = 1;
                end
            end else if (v) begin
                m_mem[m_ptr] = d;
                if (m_ptr == 127) begin
                    m_load  = 0;
                    m_done  = 1;
                    m_ready = 0;
                    m_ptr   = 0;
                end else begin
                    m_ptr++;
                end
            end
        end
    endtask

    task automatic cycle(input logic [6:0] a, input logic w, input logic s,
                         input logic v, input logic [3:0] d);
        cpu_daout = a;
        cpu_wcyc  = w;
        ld_start  = s;
        ld_valid  = v;
        ld_data   = d;
        @(posedge clk);
        model_step(a, w, s, v, d);
        #1;
        check("model_cpu_data", cpu_data, m_data);
        check("model_cpu_rst_n", cpu_rst_n, m_rst_n);
        check("model_ld_ready", ld_ready, m_ready);
        check("model_ld_done", ld_done, m_done);
        check("model_wp_hit", wp_hit, m_wp);
    endtask

    task automatic apply_reset();
        cpu_daout = '0;
        cpu_wcyc  = 0;
        ld_start  = 0;
        ld_valid  = 0;
        ld_data   = '0;
        rst_n     = 0;
        #1;
        model_reset();
        check("rst_cpu_data", cpu_data, 4'h8);
        check("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_ld_done", ld_done, 1'b0);
        check("rst_wp_hit", wp_hit, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n     = 1;
        cpu_daout = '0;
        cpu_wcyc  = 0;
        ld_start  = 0;
        ld_valid  = 0;
        ld_data   = '0;
        #2;
        apply_reset();

        // Idle read, CPU writes (last wins), write protection.
        vt[0]  = '{7'h05, 1'b0, 4'h8, 1'b1, 1'b0, "idle_read_05"};
        vt[1]  = '{7'h50, 1'b0, 4'h8, 1'b1, 1'b0, "read_50"};
        vt[2]  = '{7'h03, 1'b1, 4'h8, 1'b1, 1'b0, "write_3_to_50"};
        vt[3]  = '{7'h50, 1'b0, 4'h3, 1'b1, 1'b0, "reread_50_is_3"};
        vt[4]  = '{7'h05, 1'b1, 4'h3, 1'b1, 1'b0, "write_5_to_50"};
        vt[5]  = '{7'h06, 1'b1, 4'h3, 1'b1, 1'b0, "write_6_to_50"};
        vt[6]  = '{7'h50, 1'b0, 4'h6, 1'b1, 1'b0, "reread_50_is_6"};
        vt[7]  = '{7'h20, 1'b0, 4'h8, 1'b1, 1'b0, "read_20"};
        vt[8]  = '{7'h01, 1'b1, 4'h8, 1'b1, WP,   "write_1_to_20"};
        vt[9]  = '{7'h20, 1'b0, (WP ? 4'h8 : 4'h1), 1'b1, 1'b0, "reread_20"};
        vt[10] = '{7'h7F, 1'b0, 4'h8, 1'b1, 1'b0, "read_7f"};
        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].a, vt[i].w, 1'b0, 1'b0, 4'h0);
            check({vt[i].name, "_data"}, cpu_data, vt[i].exp_data);
            check({vt[i].name, "_rst_n"}, cpu_rst_n, vt[i].exp_rst_n);
            check({vt[i].name, "_wp"}, wp_hit, vt[i].exp_wp);
        end

        // Full load with ignored CPU writes during LOAD.
        cycle(7'h00, 1'b0, 1'b1, 1'b0, 4'h0);
        check("load_start_ready", ld_ready, 1'b1);
        check("load_start_cpu_rst", cpu_rst_n, 1'b0);
        for (int i = 0; i < 128; i++) begin
            cycle(7'h11, 1'b1, 1'b0, 1'b1, 4'(i));
            if (i == 127) begin
                check("load_done_pulse", ld_done, 1'b1);
                check("load_done_ready", ld_ready, 1'b0);
                check("load_done_cpu_rst", cpu_rst_n, 1'b0);
            end else if (i == 5) begin
                check("load_mid_data_nop", cpu_data, 4'h8);
            end
        end
        cycle(7'h2A, 1'b0, 1'b0, 1'b0, 4'h0);
        check("load_release_cpu_rst", cpu_rst_n, 1'b1);
        check("load_done_cleared", ld_done, 1'b0);
        check("load_read_2a", cpu_data, 4'hA);
        cycle(7'h7F, 1'b0, 1'b0, 1'b0, 4'h0);
        check("load_read_7f", cpu_data, 4'hF);

        // Restart at ptr=40 with a concurrent beat, then gaps.
        cycle(7'h00, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 40; i++) cycle(7'h00, 1'b0, 1'b0, 1'b1, 4'h5);
        cycle(7'h00, 1'b0, 1'b1, 1'b1, 4'hC);
        cycle(7'h00, 1'b0, 1'b0, 1'b1, 4'h7);
        for (int i = 0; i < 3; i++) cycle(7'h00, 1'b0, 1'b0, 1'b0, 4'hE);
        for (int i = 2; i < 128; i++) cycle(7'h00, 1'b0, 1'b0, 1'b1, 4'(i));
        check("restart_done_pulse", ld_done, 1'b1);
        cycle(7'h00, 1'b0, 1'b0, 1'b0, 4'h0);
        check("restart_addr0", cpu_data, 4'hC);
        cycle(7'h01, 1'b0, 1'b0, 1'b0, 4'h0);
        check("restart_addr1", cpu_data, 4'h7);
        cycle(7'h02, 1'b0, 1'b0, 1'b0, 4'h0);
        check("restart_addr2", cpu_data, 4'h2);

        // Reset at ptr=60 discards the partial image.
        cycle(7'h00, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 60; i++) cycle(7'h00, 1'b0, 1'b0, 1'b1, 4'h3);
        apply_reset();
        for (int i = 0; i < 128; i++) begin
            cycle(7'(i), 1'b0, 1'b0, 1'b0, 4'h0);
            check("post_reset_nop", cpu_data, 4'h8);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(7'($urandom_range(0, 127)),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frog_bus_mem.md
# frog_bus_mem

Program/data memory that sits directly on the frog CPU's external bus: it consumes the CPU's 7-bit `daout` address/data bus and `wcyc` write strobe, and returns 4-bit nibbles on the CPU's `data` input. It also owns a handshaked loader port that holds the CPU in reset while a 128-nibble program image is streamed in, then releases it. It replaces the behavioural memory model in bench and silicon-level integration.

## Interface

Parameters:
- `ADDR_W`, 7, CPU address width; depth is 2^ADDR_W nibbles.
- `DATA_W`, 4, nibble width.
- `PROT_TOP`, 7'h3F, highest write-protected address when `FROG_MEM_WP_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_daout`  in  7  CPU bus: address when `cpu_wcyc`=0; write data in bits [3:0] when `cpu_wcyc`=1.
- `cpu_wcyc`  in  1  CPU write-cycle strobe.
- `cpu_data`  out  4  registered read data to CPU.
- `cpu_rst_n`  out  1  registered active-low reset to CPU.
- `ld_start`  in  1  single-cycle pulse to begin or restart a program load.
- `ld_valid`  in  1  loader nibble valid.
- `ld_data`  in  4  loader nibble.
- `ld_ready`  out  1  registered; high in LOAD.
- `ld_done`  out  1  one-cycle pulse when the last nibble is accepted.
- `wp_hit`  out  1  one-cycle pulse when a CPU write is dropped by write protection.

## Operation

- Storage: 128 x 4 flops. All entries reset to 4'h8 (NOP).
- FSM states: RUN, LOAD. Reset state: RUN.
- RUN:
  - `cpu_wcyc`=0: `last_addr <= cpu_daout`, `cpu_data <= mem[cpu_daout]`.
  - `cpu_wcyc`=1: `mem[last_addr] <= cpu_daout[3:0]`. `cpu_data` and `last_addr` hold.
  - Back-to-back write cycles all target the same `last_addr`; the last write wins.
  - `ld_start`=1: go to LOAD, `ptr <= 0`, `cpu_rst_n <= 0`, `ld_ready <= 1`. The CPU access in that same cycle is still serviced.
- LOAD:
  - `cpu_data` = 4'h8. CPU writes are ignored and `wp_hit` stays 0.
  - `ld_valid & ld_ready`: `mem[ptr] <= ld_data`, `ptr <= ptr+1`.
  - `ld_start` restarts the load at `ptr` = 0. A concurrent valid beat is written to address 0 and `ptr` becomes 1.
  - Accepting a beat at `ptr`=127: `ld_done` pulses, `ld_ready <= 0`, state returns to RUN, and `cpu_rst_n` goes 1 one cycle later. `ptr` wraps to 0.
- Reset values: `cpu_data`=4'h8, `cpu_rst_n`=0 (goes 1 on the first clock after `rst_n` rises), `ld_ready`=0, `ld_done`=0, `wp_hit`=0, `last_addr`=0, `ptr`=0.
- `rst_n` asserted mid-LOAD or mid-write: immediate return to RUN with all memory restored to 4'h8. A partial image is lost.

## Timing

- Read latency: 1 cycle. An address presented at edge N yields data valid after edge N+1.
- Write commits at the edge that samples `cpu_wcyc`=1. A read of the same address in the following cycle returns the new data.
- Loader: one nibble per cycle maximum. A full load takes at least 128 accepting cycles after `ld_start`.
- `cpu_rst_n` stays low from the cycle after `ld_start` until one cycle after `ld_done`.

## Configuration

- `FROG_MEM_WP_EN` defined:
  - CPU writes with `last_addr` <= `PROT_TOP` are dropped, and `wp_hit` pulses for one cycle.
  - Loader writes are never protected.
- `FROG_MEM_WP_EN` undefined: every CPU write lands and `wp_hit` is tied 0.

## Test plan

- Reset then idle read: hold `rst_n`=0, release, present `cpu_daout`=7'h05 with `wcyc`=0 -> `cpu_data`=4'h8 one cycle later; `cpu_rst_n`=1 one cycle after release.
- Full load: pulse `ld_start`, stream nibbles `i[3:0]` for i=0..127 with `ld_valid` held high -> `ld_done` pulses on beat 127, then `cpu_rst_n`=1. Reading addr 7'h2A returns 4'hA, addr 7'h7F returns 4'hF.
- CPU write: read addr 7'h50, then `wcyc`=1 with `cpu_daout[3:0]`=4'h3 -> a re-read of 7'h50 returns 4'h3. A second consecutive write cycle of 4'h6 leaves 7'h50 = 4'h6.
- Write protect: read 7'h20, then write 4'h1 -> with `FROG_MEM_WP_EN`, `wp_hit`=1 for one cycle and 7'h20 still holds its prior value. Without the macro, 7'h20 = 4'h1 and `wp_hit`=0.
- Restart and backpressure: mid-load at `ptr`=40, pulse `ld_start` with `ld_valid`=1 and `ld_data`=4'hC -> addr 0 = 4'hC and the next beat lands at addr 1. Gaps with `ld_valid`=0 do not advance `ptr`.
- Reset mid-load: assert `rst_n` at `ptr`=60 -> `ld_ready`=0, `cpu_rst_n`=0, and after release every address reads 4'h8.
